panel_sequencer: RTL

//  Executes debounced front-panel commands (clear, extd addr load, addr load, dep, exam, cont).

---
 rtl/panel_sequencer_pkg.sv | 49 ++++
 rtl/panel_sequencer_if.sv | 16 +
 rtl/panel_sequencer_mem_if.sv | 64 ++++++
 rtl/panel_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/panel_sequencer_pkg.sv
// Shared types and constants for the front-panel sequencer.
// Words use PDP-8 numbering on paper (bit 0 = MSB), but they are stored as
// [11:0] vectors. So PDP bits 6:8 are vector bits [5:3], and PDP bits 9:11
// are vector bits [2:0].
package panel_sequencer_pkg;

    localparam int ADDR_W      = 12;
    localparam int FIELD_W     = 3;
    localparam int MAW         = FIELD_W + ADDR_W;
    localparam int TMO_W       = 5;
    localparam int DEF_MEM_TMO = 31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_MWR,
        ST_MRD,
        ST_INC,
        ST_VFY,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_EXTD,
        CMD_ADDR,
        CMD_DEP,
        CMD_EXAM,
        CMD_CONT
    } cmd_t;

    // When several switches are held together, the most destructive
    // command wins.
    function automatic cmd_t decodeCmd(input logic clr, input logic extd,
                                       input logic addr, input logic dep,
                                       input logic exam, input logic cont);
        cmd_t c;
        c = CMD_NONE;
        if (clr)       c = CMD_CLEAR;
        else if (extd) c = CMD_EXTD;
        else if (addr) c = CMD_ADDR;
        else if (dep)  c = CMD_DEP;
        else if (exam) c = CMD_EXAM;
        else if (cont) c = CMD_CONT;
        return c;
    endfunction

endpackage

// File: rtl/panel_sequencer_if.sv
// Request/acknowledge memory port between the panel sequencer and the arbiter.
interface panel_sequencer_if;
    import panel_sequencer_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [MAW-1:0]    mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/panel_sequencer_mem_if.sv
// panel_mem_if: holds one memory request until it is acknowledged or times out.
// It also captures the read data when the acknowledge arrives.
module panel_mem_if
    import panel_sequencer_pkg::*;
#(
    parameter int MEM_TMO = DEF_MEM_TMO
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [MAW-1:0]    addr_i,
    input  logic [ADDR_W-1:0] wdata_i,
    output logic              ack_o,
    output logic              tmo_o,
    output logic [ADDR_W-1:0] rdata_o,
    panel_sequencer_if.master mem
);

    logic              req_q;
    logic              we_q;
    logic [MAW-1:0]    addr_q;
    logic [ADDR_W-1:0] wdata_q;
    logic [ADDR_W-1:0] rdata_q;
    logic [TMO_W-1:0]  cnt_q;

    assign ack_o = req_q & mem.mem_ack;
    assign tmo_o = req_q & ~mem.mem_ack & (cnt_q == TMO_W'(MEM_TMO - 1));

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign rdata_o       = rdata_q;

    // A new start wins over a completing access, so a readback can follow a
    // write back-to-back. Each start restarts the wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (ack_o)
                rdata_q <= mem.mem_rdata;
            if (start_i) begin
                req_q   <= 1'b1;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                cnt_q   <= '0;
            end else if (ack_o || tmo_o) begin
                req_q <= 1'b0;
                cnt_q <= '0;
            end else if (req_q) begin
                cnt_q <= cnt_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: rtl/panel_sequencer.sv
// panel_sequencer: runs debounced front-panel commands against the panel PC,
// the IF/DF field registers, the MB display register and the memory port.
// Optional build macro PANEL_READBACK_EN: after each deposit, the word is
// read back and compared with the written value.
module panel_sequencer
    import panel_sequencer_pkg::*;
#(
    parameter int MEM_TMO = DEF_MEM_TMO
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               triggerd,
    input  logic               cleard,
    input  logic               extd_addrd,
    input  logic               addr_loadd,
    input  logic               depd,
    input  logic               examd,
    input  logic               contd,
    input  logic [ADDR_W-1:0]  sr,
    panel_sequencer_if.master  mem,
    output logic [ADDR_W-1:0]  pc,
    output logic [FIELD_W-1:0] ifr,
    output logic [FIELD_W-1:0] dfr,
    output logic [ADDR_W-1:0]  mb,
    output logic               clear_strb,
    output logic               run_req,
    output logic               busy,
    output logic               err
);

    state_t             state_q;
    cmd_t               cmd_q;
    logic [ADDR_W-1:0]  sr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [FIELD_W-1:0] ifr_q;
    logic [FIELD_W-1:0] dfr_q;
    logic [ADDR_W-1:0]  mb_q;
    logic               trig_q;
    logic               clearStrb_q;
    logic               runReq_q;
    logic               err_q;

    logic               trigEdge;
    logic               memStart;
    logic               memStartWe;
    logic               memAck;
    logic               memTmo;
    logic [ADDR_W-1:0]  memRdata;
    logic [ADDR_W-1:0]  pcInc_d;

    assign trigEdge   = triggerd & ~trig_q;
    assign pcInc_d    = pc_q + ADDR_W'(1);
    assign memStartWe = (state_q == ST_DECODE) && (cmd_q == CMD_DEP);
    assign memStart   = ((state_q == ST_DECODE) && ((cmd_q == CMD_DEP) || (cmd_q == CMD_EXAM)))
`ifdef PANEL_READBACK_EN
                      || ((state_q == ST_MWR) && memAck)
`endif
                      ;

    panel_mem_if #(.MEM_TMO(MEM_TMO)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .start_i (memStart),
        .we_i    (memStartWe),
        .addr_i  ({ifr_q, pc_q}),
        .wdata_i (sr_q),
        .ack_o   (memAck),
        .tmo_o   (memTmo),
        .rdata_o (memRdata),
        .mem     (mem)
    );

    assign pc         = pc_q;
    assign ifr        = ifr_q;
    assign dfr        = dfr_q;
    assign mb         = mb_q;
    assign clear_strb = clearStrb_q;
    assign run_req    = runReq_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);

    // Command FSM. A new command is latched only on a trigger rising edge
    // while idle. Strobes are one-cycle pulses raised on leaving DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_NONE;
            sr_q        <= '0;
            pc_q        <= '0;
            ifr_q       <= '0;
            dfr_q       <= '0;
            mb_q        <= '0;
            trig_q      <= 1'b0;
            clearStrb_q <= 1'b0;
            runReq_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            trig_q      <= triggerd;
            clearStrb_q <= 1'b0;
            runReq_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trigEdge) begin
                        cmd_q   <= decodeCmd(cleard, extd_addrd, addr_loadd,
                                             depd, examd, contd);
                        sr_q    <= sr;
                        state_q <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_q <= ST_DONE;
                    case (cmd_q)
                        CMD_CLEAR: begin
                            clearStrb_q <= 1'b1;
                            err_q       <= 1'b0;
                        end
                        CMD_EXTD: begin
                            ifr_q <= sr_q[5:3];
                            dfr_q <= sr_q[2:0];
                        end
                        CMD_ADDR: pc_q     <= sr_q;
                        CMD_DEP:  state_q  <= ST_MWR;
                        CMD_EXAM: state_q  <= ST_MRD;
                        CMD_CONT: runReq_q <= 1'b1;
                        default:  ;
                    endcase
                end
                ST_MWR: begin
                    if (memAck) begin
                        mb_q <= sr_q;
`ifdef PANEL_READBACK_EN
                        state_q <= ST_VFY;
`else
                        state_q <= ST_INC;
`endif
                    end else if (memTmo) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_MRD, ST_VFY: begin
                    if (memAck) begin
                        state_q <= ST_INC;
                    end else if (memTmo) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_INC: begin
                    pc_q <= pcInc_d;
                    if (cmd_q == CMD_EXAM)
                        mb_q <= memRdata;
`ifdef PANEL_READBACK_EN
                    if ((cmd_q == CMD_DEP) && (memRdata != sr_q))
                        err_q <= 1'b1;
`endif
                    state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
